// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// One byte is accepted in IDLE and serialised with CLK_DIV clock cycles per bit.
module uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic             stop_cnt, stop_next;
    logic [7:0]       data_q, data_next;
    logic             txd_next;
    logic             bit_end;

    // Parity over the latched byte; odd parity is the inverse of even parity.
    function automatic logic parity_bit(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;
    assign bit_end  = (baud_cnt == CNT_MAX);

    // State and line registers; txd is registered so it only moves at bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            data_q   <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            stop_cnt <= stop_next;
            data_q   <= data_next;
            txd      <= txd_next;
        end
    end

    // Next-state logic: the baud counter restarts at every bit, txd_next is the level of the upcoming bit.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        stop_next  = stop_cnt;
        data_next  = data_q;
        txd_next   = txd;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (tx_valid) begin
                    state_next = START;
                    data_next  = tx_data;
                    baud_next  = '0;
                    bit_next   = '0;
                    stop_next  = 1'b0;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                    txd_next   = data_q[0];
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            txd_next   = parity_bit(data_q);
                        end else begin
                            state_next = STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                        txd_next = data_q[bit_cnt + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                    txd_next   = 1'b1;
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_end) begin
                    baud_next = '0;
                    if (STOP_BITS == 2 && stop_cnt == 1'b0) begin
                        stop_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor
// decodes the selected transmitter cycle by cycle and compares.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par;
        int         nstop;
        int         div;
        int         gap;
        int         trunc;
        int         start_cyc;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [1:0] sel;
    logic [3:0] valid_v, ready_v, txd_v, busy_v;
    logic       ready_m, txd_m, busy_m;
    logic       rst_done = 1'b0;
    logic       mon_busy = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    frame_t     exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_v = tx_valid ? (4'b0001 << sel) : 4'b0000;
    assign ready_m = ready_v[sel];
    assign txd_m   = txd_v[sel];
    assign busy_m  = busy_v[sel];

    uart_tx #(.CLK_DIV(4)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));
    uart_tx #(.CLK_DIV(5), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));
    uart_tx #(.CLK_DIV(3), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));
    uart_tx #(.CLK_DIV(4), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_v[3]),
        .tx_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic pe, input logic p,
                                  input int ns, input int dv, input int gap, input int trunc);
        frame_t f;
        f.data = d; f.par_en = pe; f.par = p; f.nstop = ns; f.div = dv;
        f.gap = gap; f.trunc = trunc; f.start_cyc = 0;
        return f;
    endfunction

    // Serial line image: start bit, data LSB first, optional parity, stop bits high.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic pe, input logic p);
        logic [11:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (pe) b[9] = p;
        return b;
    endfunction

    // Called right after a falling edge; offers the byte and queues the expected frame.
    task automatic send(input frame_t f, output int start);
        int w;
        tx_data  = f.data;
        tx_valid = 1'b1;
        w = 0;
        while (ready_m !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (ready_m !== 1'b1) check("accept_timeout", 32'd1, 32'd0);
        f.start_cyc = cyc + 1;
        start = f.start_cyc;
        exp_q.push_back(f);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || mon_busy) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0 || mon_busy) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: decode each frame on the selected line and compare with the queue head.
    initial begin : monitor
        frame_t      f;
        logic [11:0] bits, act_bits, seen_bad;
        int          nb, total, b, idle_cnt, rb_bad, flag;
        idle_cnt = 0;
        wait (rst_done);
        forever begin
            @(negedge clk);
            if (txd_m === 1'b1) begin
                idle_cnt++;
            end else if (exp_q.size() == 0) begin
                mon_busy = 1'b1;
                check("unexpected_frame", 32'd1, 32'd0);
                for (int w = 0; w < 1000 && ready_m !== 1'b1; w++) @(negedge clk);
                idle_cnt = 0;
                mon_busy = 1'b0;
            end else begin
                mon_busy = 1'b1;
                f = exp_q.pop_front();
                if (f.gap >= 0) check($sformatf("idle_gap_%02h", f.data), idle_cnt, f.gap);
                check($sformatf("start_cycle_%02h", f.data), cyc, f.start_cyc);
                bits = frame_bits(f.data, f.par_en, f.par);
                nb = 9 + int'(f.par_en) + f.nstop;
                total = (f.trunc > 0) ? f.trunc : nb * f.div;
                seen_bad = '0;
                act_bits = '1;
                rb_bad = 0;
                for (int fc = 0; fc < total; fc++) begin
                    if (fc > 0) @(negedge clk);
                    b = fc / f.div;
                    if (fc % f.div == 0) act_bits[b] = txd_m;
                    if (txd_m !== bits[b] && !seen_bad[b]) begin
                        seen_bad[b] = 1'b1;
                        act_bits[b] = txd_m;
                    end
                    if (ready_m !== 1'b0 || busy_m !== 1'b1) rb_bad++;
                end
                for (int i = 0; i < (total + f.div - 1) / f.div; i++)
                    check($sformatf("frame_%02h_bit%0d", f.data, i), 32'(act_bits[i]), 32'(bits[i]));
                check($sformatf("ready_busy_in_frame_%02h", f.data), rb_bad, 0);
                if (f.trunc == 0) begin
                    @(negedge clk);
                    check($sformatf("post_frame_ready_%02h", f.data), 32'(ready_m), 32'd1);
                    check($sformatf("post_frame_txd_%02h", f.data), 32'(txd_m), 32'd1);
                    idle_cnt = 1;
                end else begin
                    flag = 0;
                    repeat (40) begin
                        @(negedge clk);
                        if (ready_m !== 1'b1 || txd_m !== 1'b1 || busy_m !== 1'b0) flag++;
                    end
                    check("abort_idle", flag, 0);
                    idle_cnt = 40;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed vectors with hand-computed parity and timing.
    initial begin : stimulus
        int s, w;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; sel = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready_v), 32'hF);
        check("reset_busy", 32'(busy_v), 32'h0);
        check("reset_txd", 32'(txd_v), 32'hF);
        rst = 1'b0;
        rst_done = 1'b1;
        @(negedge clk);

        // 0x55, 4 clocks per bit, 10 bits
        send(mk(8'h55, 1'b0, 1'b0, 1, 4, -1, 0), s);
        wait_drain();

        // tx_valid held high: 0x12 then 0x34 accepted on the single idle cycle
        @(negedge clk);
        send(mk(8'h12, 1'b0, 1'b0, 1, 4, -1, 0), s);
        tx_valid = 1'b1;
        w = 0;
        while (ready_m !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        tx_data = 8'h34;
        exp_q.push_back(mk(8'h34, 1'b0, 1'b0, 1, 4, 1, 0));
        exp_q[exp_q.size()-1].start_cyc = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain();

        // tx_data changed and tx_valid pulsed mid-frame: no effect, no second frame
        @(negedge clk);
        send(mk(8'h5A, 1'b0, 1'b0, 1, 4, -1, 0), s);
        for (int i = 0; i < 100 && cyc != s + 10; i++) @(negedge clk);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain();
        repeat (60) @(negedge clk);

        // reset during data bit 3 (frame cycles 16..19) aborts the frame
        send(mk(8'h00, 1'b0, 1'b0, 1, 4, -1, 18), s);
        for (int i = 0; i < 100 && cyc != s + 17; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_drain();

        // reset beats a simultaneous tx_valid; first valid edge afterwards is accepted
        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hAA;
        @(negedge clk);
        rst = 1'b0;
        check("ready_after_rst", 32'(ready_m), 32'd1);
        send(mk(8'h3C, 1'b0, 1'b0, 1, 4, -1, 0), s);
        wait_drain();

        // even parity, 5 clocks per bit: 0xA5 -> 0, 0x01 -> 1
        sel = 2'd1;
        @(negedge clk);
        send(mk(8'hA5, 1'b1, 1'b0, 1, 5, -1, 0), s);
        wait_drain();
        @(negedge clk);
        send(mk(8'h01, 1'b1, 1'b1, 1, 5, -1, 0), s);
        wait_drain();

        // odd parity, 3 clocks per bit: 0xA5 -> 1, 0x00 -> 1
        sel = 2'd2;
        @(negedge clk);
        send(mk(8'hA5, 1'b1, 1'b1, 1, 3, -1, 0), s);
        wait_drain();
        @(negedge clk);
        send(mk(8'h00, 1'b1, 1'b1, 1, 3, -1, 0), s);
        wait_drain();

        // two stop bits: 0xFF -> 4 low then 40 high
        sel = 2'd3;
        @(negedge clk);
        send(mk(8'hFF, 1'b0, 1'b0, 2, 4, -1, 0), s);
        wait_drain();

        repeat (30) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 The module SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after data bit 7.
REQ-003 The module SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 The module SHALL have parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port tx_data, input, 8 bits: byte to send.
REQ-008 The module SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-009 The module SHALL have port tx_ready, output, 1 bit: the module can accept a byte this cycle.
REQ-010 The module SHALL have port txd, output, 1 bit: serial line, idle high, driven from a register.
REQ-011 The module SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY_EN=0.
REQ-013 tx_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of tx_ready.
REQ-014 A byte SHALL be accepted on a clk edge where tx_valid=1 and tx_ready=1; tx_data is latched on that edge, and later changes to tx_data do not affect the frame.
REQ-015 tx_valid while not in IDLE SHALL be ignored, with no queueing.
REQ-016 After acceptance, txd SHALL go low on the next edge (IDLE->START), giving one cycle of latency from acceptance to the start bit.
REQ-017 Each bit (start, each data bit, parity, each stop bit) SHALL hold txd for exactly CLK_DIV cycles, timed by a baud counter of width clog2(CLK_DIV) that restarts at 0 on every bit.
REQ-018 Data bits SHALL be sent LSB first, with bit counter 0..7; DATA exits after bit 7's period ends.
REQ-019 The parity bit SHALL be the XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
REQ-020 STOP SHALL drive txd=1 for STOP_BITS*CLK_DIV cycles and then return to IDLE.
REQ-021 The frame length SHALL be (10+PARITY_EN+STOP_BITS-1)*CLK_DIV cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-022 After the last stop cycle the FSM SHALL be in IDLE for at least 1 cycle with txd=1.
REQ-023 Holding tx_valid=1 continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle.
REQ-024 txd SHALL never glitch; it changes only at bit boundaries.
REQ-025 txd SHALL equal 1 in IDLE.

Reset
REQ-026 While rst=1 at a clk edge, the module SHALL set state to IDLE, txd=1, tx_ready=1, busy=0, and clear the baud counter, bit counter and latched data to 0.
REQ-027 rst asserted mid-frame SHALL abort the frame: txd=1 after that edge with no further frame bits, and the aborted byte is discarded.
REQ-028 rst SHALL take priority over a simultaneous tx_valid, so that no byte is accepted in a reset cycle.
REQ-029 After rst deasserts, the module SHALL accept a byte on the first edge with tx_valid=1.

Verification
REQ-030 The bench SHALL cover: CLK_DIV=4, no parity, 1 stop, send 0x55 -> txd = 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles (40 cycles total), tx_ready=0 throughout and 1 on the next cycle.
REQ-031 The bench SHALL cover: PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; send 0x01 even -> parity bit 1.
REQ-032 The bench SHALL cover: STOP_BITS=2, CLK_DIV=4, send 0xFF -> start 4 cycles low, then 40 cycles high (8 data + 2 stop), then IDLE.
REQ-033 The bench SHALL cover: tx_valid held high with 0x12 then 0x34 -> two frames with exactly one idle-high cycle between them, and 0x34 accepted on that IDLE cycle.
REQ-034 The bench SHALL cover: rst pulsed 1 cycle during data bit 3 -> txd=1 from the next edge, tx_ready=1, and no further low bits until a new acceptance.
REQ-035 The bench SHALL cover: tx_data changed and tx_valid pulsed during a frame -> serial output equals the originally latched byte and no second frame is sent.
